// File: rtl/mips_run_ctrl_if.sv
// Program-stream and CPU instruction-port bundle for mips_run_ctrl.
// The slave side is the run controller. The master side is the host that
// feeds program words, together with the CPU that receives them and reports
// its PC.
interface mips_run_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              S_VALID;
  logic [DATA_W-1:0] S_DATA;
  logic              S_READY;
  logic              CPU_RST;
  logic [DATA_W-1:0] W_Ins;
  logic              WE;
  logic [ADDR_W-1:0] CPU_PC;

  modport master (
    output S_VALID, S_DATA, CPU_PC,
    input  S_READY, CPU_RST, W_Ins, WE
  );

  modport slave (
    input  S_VALID, S_DATA, CPU_PC,
    output S_READY, CPU_RST, W_Ins, WE
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Program-load and run controller for SingleCycleClockMIPS.
// While the CPU is held in reset, the controller streams program words into
// the CPU instruction memory. It then releases reset and runs the CPU until
// one of three exits: a stop PC, a cycle limit or an abort. Status, cycle
// count and final PC stay visible afterwards.
module mips_run_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 9,
  parameter int CNT_W    = 16,
  parameter int RST_HOLD = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [LEN_W-1:0]  LEN,
  input  logic [ADDR_W-1:0] STOP_PC,
  input  logic [CNT_W-1:0]  CYCLE_LIMIT,
  input  logic              ABORT,
  mips_run_ctrl_if.slave    bus,
  output logic              BUSY,
  output logic              DONE,
  output logic [1:0]        STATUS,
  output logic [CNT_W-1:0]  CYCLES,
  output logic [ADDR_W-1:0] FINAL_PC
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [1:0] ST_STOP  = 2'b01;
  localparam logic [1:0] ST_LIMIT = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, FIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  load_cnt;
  logic [ADDR_W-1:0] stop_q;
  logic [CNT_W-1:0]  limit_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cycles_inc;
  logic [1:0]        status_nxt;
  logic              start_acc;
  logic              hs;
  logic              last_word;
  logic              hold_done;
  logic              pc_match;
  logic              limit_hit;
  logic              active;
  logic              to_fin;

  // The cycle counter sticks at all-ones instead of wrapping when no limit is set.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // START is accepted only when the controller is idle or finished.
  assign start_acc  = START && (state == IDLE || state == FIN);
  // A same-cycle abort suppresses the word, so nothing is written after an abort.
  assign hs         = bus.S_VALID && bus.S_READY && !ABORT;
  assign last_word  = (load_cnt + LEN_W'(1)) == len_q;
  assign hold_done  = hold_cnt == HOLD_W'(RST_HOLD - 1);
  assign cycles_inc = sat_inc(CYCLES);
  assign pc_match   = bus.CPU_PC == stop_q;
  assign limit_hit  = (limit_q != '0) && (cycles_inc == limit_q);
  assign active     = state inside {LOAD, HOLD, RUN};

  // Next-state selection. Abort outranks the stop PC, which outranks the limit.
  always_comb begin
    state_nxt  = state;
    status_nxt = 2'b00;
    to_fin     = 1'b0;
    if (active && ABORT) begin
      state_nxt  = FIN;
      status_nxt = ST_ABORT;
      to_fin     = 1'b1;
    end else begin
      case (state)
        IDLE, FIN: if (START) state_nxt = (LEN == '0) ? HOLD : LOAD;
        LOAD:      if (hs && last_word) state_nxt = HOLD;
        HOLD:      if (hold_done) state_nxt = RUN;
        RUN: begin
          if (pc_match) begin
            state_nxt  = FIN;
            status_nxt = ST_STOP;
            to_fin     = 1'b1;
          end else if (limit_hit) begin
            state_nxt  = FIN;
            status_nxt = ST_LIMIT;
            to_fin     = 1'b1;
          end
        end
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // State register. The control outputs are registered from the next state, so no input feeds an output combinationally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      bus.S_READY <= 1'b0;
      bus.CPU_RST <= 1'b1;
    end else begin
      state       <= state_nxt;
      BUSY        <= state_nxt inside {LOAD, HOLD, RUN};
      DONE        <= state_nxt == FIN;
      bus.S_READY <= state_nxt == LOAD;
      bus.CPU_RST <= state_nxt inside {IDLE, LOAD, HOLD};
    end
  end

  // Instruction write port, load/hold counters, run counter and exit results.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.W_Ins <= '0;
      bus.WE    <= 1'b0;
      load_cnt  <= '0;
      hold_cnt  <= '0;
      STATUS    <= 2'b00;
      CYCLES    <= '0;
      FINAL_PC  <= '0;
    end else begin
      bus.WE <= hs;
      if (hs) bus.W_Ins <= bus.S_DATA;

      if (start_acc) load_cnt <= '0;
      else if (hs)   load_cnt <= load_cnt + LEN_W'(1);

      if (state == HOLD && state_nxt == HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
      else                                    hold_cnt <= '0;

      if (start_acc) begin
        STATUS <= 2'b00;
        CYCLES <= '0;
      end else begin
        // A stop-PC or abort exit leaves the count at the cycles already completed.
        if (state == RUN && !ABORT && !pc_match) CYCLES <= cycles_inc;
        if (to_fin) begin
          STATUS   <= status_nxt;
          FINAL_PC <= bus.CPU_PC;
        end
      end
    end
  end

  // Run parameters are captured when a START is accepted.
  always_ff @(posedge CLK) begin
    if (start_acc) begin
      len_q   <= LEN;
      stop_q  <= STOP_PC;
      limit_q <= CYCLE_LIMIT;
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl. A small CPU model resets its PC to 0 while
// CPU_RST is high and otherwise steps the PC by 4 on each clock. Program
// words and run results are scoreboarded through queues.
`timescale 1ns/1ps
module tb_mips_run_ctrl;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int LEN_W    = 9;
  localparam int CNT_W    = 16;
  localparam int RST_HOLD = 2;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              START = 1'b0;
  logic              ABORT = 1'b0;
  logic [LEN_W-1:0]  LEN = '0;
  logic [ADDR_W-1:0] STOP_PC = '0;
  logic [CNT_W-1:0]  CYCLE_LIMIT = '0;
  logic              BUSY;
  logic              DONE;
  logic [1:0]        STATUS;
  logic [CNT_W-1:0]  CYCLES;
  logic [ADDR_W-1:0] FINAL_PC;

  mips_run_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  mips_run_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .LEN(LEN), .STOP_PC(STOP_PC),
    .CYCLE_LIMIT(CYCLE_LIMIT), .ABORT(ABORT), .bus(bus), .BUSY(BUSY), .DONE(DONE),
    .STATUS(STATUS), .CYCLES(CYCLES), .FINAL_PC(FINAL_PC)
  );

  always #5 CLK = ~CLK;

  // CPU model: the PC resets while CPU_RST is high and otherwise steps by one word per clock.
  logic [ADDR_W-1:0] pc_m = '0;
  always @(posedge CLK) pc_m <= bus.CPU_RST ? '0 : pc_m + 32'd4;
  assign bus.CPU_PC = pc_m;

  typedef struct packed {
    logic [1:0]        st;
    logic [CNT_W-1:0]  cyc;
    logic [ADDR_W-1:0] pc;
  } res_t;

  logic [DATA_W-1:0] word_q[$];
  res_t              res_q[$];
  logic [DATA_W-1:0] mon_exp;
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  // Write-port monitor: each cycle with WE high must carry the next queued word while the CPU is held in reset.
  always @(negedge CLK) begin
    if (bus.WE === 1'b1) begin
      we_cnt++;
      checks++;
      if (word_q.size() == 0) begin
        errors++;
        $display("FAIL we_unexpected: W_Ins=%h with no word pending", bus.W_Ins);
      end else begin
        mon_exp = word_q.pop_front();
        if ({bus.CPU_RST, bus.W_Ins} !== {1'b1, mon_exp}) begin
          errors++;
          $display("FAIL w_ins: got rst=%b data=%h expected rst=1 data=%h", bus.CPU_RST, bus.W_Ins, mon_exp);
        end
      end
    end
  end

  function automatic void push_res(input logic [1:0] st, input logic [CNT_W-1:0] cyc,
                                   input logic [ADDR_W-1:0] pc);
    res_t e;
    e.st = st; e.cyc = cyc; e.pc = pc;
    res_q.push_back(e);
  endfunction

  task automatic do_start(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] stop,
                          input logic [CNT_W-1:0] lim);
    LEN = len; STOP_PC = stop; CYCLE_LIMIT = lim; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input int gap, output bit ok);
    ok = 1'b0;
    bus.S_VALID = 1'b0;
    repeat (gap) @(negedge CLK);
    bus.S_VALID = 1'b1;
    bus.S_DATA  = w;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (bus.S_READY === 1'b1) begin
        word_q.push_back(w);
        ok = 1'b1;
      end
      @(negedge CLK);
    end
    bus.S_VALID = 1'b0;
  endtask

  task automatic wait_cpu_run(output int n);
    n = 0;
    while (bus.CPU_RST !== 1'b0 && n < 20) begin n++; @(negedge CLK); end
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (DONE !== 1'b1 && n < max) begin n++; @(negedge CLK); end
    if (DONE !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    bus.S_VALID = 1'b0; bus.S_DATA = '0; RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bus.CPU_RST, bus.WE, bus.S_READY, BUSY, DONE, STATUS} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 1000000",
               {bus.CPU_RST, bus.WE, bus.S_READY, BUSY, DONE, STATUS});
    end
    checks++;
    if ({bus.W_Ins, CYCLES, FINAL_PC} !== '0) begin
      errors++;
      $display("FAIL reset_data: got W_Ins=%h CYCLES=%0d FINAL_PC=%h expected all 0", bus.W_Ins, CYCLES, FINAL_PC);
    end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({bus.CPU_RST, BUSY, DONE} !== 3'b100) begin
      errors++;
      $display("FAIL idle: got rst/busy/done=%b expected 100", {bus.CPU_RST, BUSY, DONE});
    end
  endtask

  task automatic test_load_stop();
    int gaps[4] = '{0, 2, 1, 3};
    bit ok;
    int n;
    res_t r;
    we_cnt = 0;
    push_res(2'b01, 16'd4, 32'h10);
    do_start(9'd4, 32'h10, 16'd0);
    checks++;
    if ({BUSY, bus.S_READY, bus.CPU_RST} !== 3'b111) begin
      errors++;
      $display("FAIL start_load: got busy/ready/rst=%b expected 111", {BUSY, bus.S_READY, bus.CPU_RST});
    end
    for (int i = 0; i < 4; i++) begin
      send_word(32'h20100001 + 32'(i), gaps[i], ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL load_hs: word %0d got no handshake expected one", i); end
    end
    wait_cpu_run(n);
    checks++;
    if (n !== RST_HOLD) begin errors++; $display("FAIL hold_len: got %0d cycles expected %0d", n, RST_HOLD); end
    checks++;
    if (we_cnt !== 4 || word_q.size() !== 0) begin
      errors++;
      $display("FAIL we_count: got %0d writes, %0d pending expected 4, 0", we_cnt, word_q.size());
    end
    wait_done(100, n);
    r = res_q.pop_front();
    checks++;
    if (n < 0) begin errors++; $display("FAIL stop_done: got no DONE expected DONE within 100 cycles"); end
    checks++;
    if ({STATUS, CYCLES, FINAL_PC, BUSY, bus.CPU_RST} !== {r.st, r.cyc, r.pc, 2'b00}) begin
      errors++;
      $display("FAIL stop_exit: got st=%b cyc=%0d pc=%h busy=%b rst=%b expected st=%b cyc=%0d pc=%h busy=0 rst=0",
               STATUS, CYCLES, FINAL_PC, BUSY, bus.CPU_RST, r.st, r.cyc, r.pc);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    res_t r;
    push_res(2'b10, 16'd160, 32'h27C);
    do_start(9'd1, 32'hFFFFFFFC, 16'd160);
    checks++;
    if ({DONE, STATUS, CYCLES, bus.CPU_RST} !== {1'b0, 2'b00, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart_clear: got done=%b st=%b cyc=%0d rst=%b expected 0 00 0 1", DONE, STATUS, CYCLES, bus.CPU_RST);
    end
    send_word(32'h20100005, 1, ok);
    wait_cpu_run(n);
    wait_done(400, n);
    r = res_q.pop_front();
    checks++;
    if (n !== 160) begin errors++; $display("FAIL timeout_len: got DONE after %0d run cycles expected 160", n); end
    checks++;
    if ({STATUS, CYCLES, FINAL_PC} !== {r.st, r.cyc, r.pc}) begin
      errors++;
      $display("FAIL timeout_exit: got st=%b cyc=%0d pc=%h expected st=%b cyc=%0d pc=%h",
               STATUS, CYCLES, FINAL_PC, r.st, r.cyc, r.pc);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    res_t r;
    push_res(2'b01, 16'd4, 32'h10);
    do_start(9'd0, 32'h10, 16'd5);
    checks++;
    if ({BUSY, bus.S_READY, bus.CPU_RST} !== 3'b101) begin
      errors++;
      $display("FAIL len0_hold: got busy/ready/rst=%b expected 101", {BUSY, bus.S_READY, bus.CPU_RST});
    end
    wait_done(100, n);
    r = res_q.pop_front();
    checks++;
    if ({STATUS, CYCLES, FINAL_PC} !== {r.st, r.cyc, r.pc}) begin
      errors++;
      $display("FAIL both_exit: got st=%b cyc=%0d pc=%h expected st=%b cyc=%0d pc=%h",
               STATUS, CYCLES, FINAL_PC, r.st, r.cyc, r.pc);
    end
  endtask

  task automatic test_abort();
    bit ok;
    res_t r;
    we_cnt = 0;
    push_res(2'b11, 16'd0, 32'h0);
    do_start(9'd5, 32'h10, 16'd0);
    send_word(32'h20100011, 0, ok);
    send_word(32'h20100012, 1, ok);
    ABORT = 1'b1; bus.S_VALID = 1'b1; bus.S_DATA = 32'hDEADBEEF;
    @(negedge CLK);
    ABORT = 1'b0; bus.S_VALID = 1'b0;
    r = res_q.pop_front();
    checks++;
    if ({DONE, BUSY, bus.S_READY} !== 3'b100) begin
      errors++;
      $display("FAIL abort_ctrl: got done/busy/ready=%b expected 100", {DONE, BUSY, bus.S_READY});
    end
    checks++;
    if ({STATUS, CYCLES, FINAL_PC} !== {r.st, r.cyc, r.pc}) begin
      errors++;
      $display("FAIL abort_exit: got st=%b cyc=%0d pc=%h expected st=%b cyc=%0d pc=%h",
               STATUS, CYCLES, FINAL_PC, r.st, r.cyc, r.pc);
    end
    @(negedge CLK);
    checks++;
    if (we_cnt !== 2) begin errors++; $display("FAIL abort_we: got %0d writes expected 2", we_cnt); end
  endtask

  task automatic test_restart_ignore();
    int n;
    res_t r;
    push_res(2'b10, 16'd20, 32'h4C);
    do_start(9'd0, 32'hFFFFFFFC, 16'd20);
    wait_cpu_run(n);
    for (int p = 0; p < 2; p++) begin
      repeat (3) @(negedge CLK);
      do_start(9'd3, 32'h8, 16'd2);
      checks++;
      if ({BUSY, bus.S_READY, bus.CPU_RST, DONE} !== 4'b1000) begin
        errors++;
        $display("FAIL start_in_run: pulse %0d got busy/ready/rst/done=%b expected 1000", p,
                 {BUSY, bus.S_READY, bus.CPU_RST, DONE});
      end
    end
    wait_done(100, n);
    r = res_q.pop_front();
    checks++;
    if ({STATUS, CYCLES, FINAL_PC} !== {r.st, r.cyc, r.pc}) begin
      errors++;
      $display("FAIL restart_exit: got st=%b cyc=%0d pc=%h expected st=%b cyc=%0d pc=%h",
               STATUS, CYCLES, FINAL_PC, r.st, r.cyc, r.pc);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int n;
    do_start(9'd2, 32'hFFFFFFFC, 16'd0);
    send_word(32'h20100021, 0, ok);
    send_word(32'h20100022, 0, ok);
    wait_cpu_run(n);
    repeat (5) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({bus.CPU_RST, bus.WE, bus.S_READY, BUSY, DONE, STATUS} !== 7'b1000000) begin
      errors++;
      $display("FAIL async_ctrl: got %b expected 1000000",
               {bus.CPU_RST, bus.WE, bus.S_READY, BUSY, DONE, STATUS});
    end
    checks++;
    if ({bus.W_Ins, CYCLES, FINAL_PC} !== '0) begin
      errors++;
      $display("FAIL async_data: got W_Ins=%h CYCLES=%0d FINAL_PC=%h expected all 0", bus.W_Ins, CYCLES, FINAL_PC);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_load_stop();
    test_timeout();
    test_simultaneous();
    test_abort();
    test_restart_ignore();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200us");
    $fatal(1);
  end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Synthesizable program-load and run controller for `SingleCycleClockMIPS`, replacing hand-driven reset/run sequencing. It accepts a program as a valid/ready word stream and writes it into the CPU instruction memory through the CPU's `W_Ins`/`WE` port while holding the CPU in reset. It then releases reset and runs the CPU until the PC reaches a stop address, a cycle limit expires, or an abort arrives. It reports the status, cycle count and final PC to the bench or host.

## Interface
- `DATA_W`, 32, instruction word width
- `ADDR_W`, 32, PC width
- `LEN_W`, 9, program length counter width (max 2^LEN_W-1 words)
- `CNT_W`, 16, run cycle counter width
- `RST_HOLD`, 2, cycles CPU reset is held after load (≥1)

Ports:
- `CLK` in 1: single clock, all logic on rising edge
- `RST_N` in 1: reset, asynchronous, active-low
- `START` in 1: run request pulse
- `LEN` in LEN_W: program word count, sampled on accepted START
- `STOP_PC` in ADDR_W: halt address, sampled on accepted START
- `CYCLE_LIMIT` in CNT_W: run cycle limit, sampled on accepted START; 0 = no limit
- `ABORT` in 1: terminate current operation
- `S_VALID` in 1, `S_DATA` in DATA_W, `S_READY` out 1: program word stream
- `CPU_RST` out 1: to CPU `RST`, active-high
- `W_Ins` out DATA_W, `WE` out 1: to CPU instruction write port
- `CPU_PC` in ADDR_W: from CPU `PC`
- `BUSY` out 1, `DONE` out 1, `STATUS` out 2, `CYCLES` out CNT_W, `FINAL_PC` out ADDR_W

## Operation
- CPU instruction memory contract: while `CPU_RST`=1, each cycle with `WE`=1 writes `W_Ins` to the next word address, starting at word 0 after reset assertion.
- States: IDLE, LOAD, HOLD, RUN, FIN.
- IDLE: `CPU_RST`=1. START → LOAD, capturing LEN, STOP_PC and CYCLE_LIMIT. If LEN=0, START → HOLD instead.
- LOAD: `S_READY`=1. Each S_VALID&S_READY handshake registers `W_Ins`<=S_DATA and `WE`<=1 for exactly one cycle, and increments the load count. On the handshake that makes count=LEN, `S_READY` drops and the state goes to HOLD. Stalls of any length on S_VALID=0 are allowed.
- HOLD: `CPU_RST`=1 for RST_HOLD cycles (counted from HOLD entry), then RUN.
- RUN: `CPU_RST`=0 and `CYCLES` increments each cycle.
  - `CPU_PC`==STOP_PC → FIN, STATUS=01.
  - Otherwise, limit≠0 and the next CYCLES value equals the limit → FIN, STATUS=10.
  - A stop-PC match and limit expiry in the same cycle give STATUS=01.
- ABORT in LOAD, HOLD or RUN → FIN, STATUS=11. ABORT takes priority over the other exits.
- FIN: `DONE`=1 and `FINAL_PC` holds the PC sampled on the exit cycle. CYCLES is frozen. `CPU_RST` stays 0, so the CPU free-runs and register contents stay readable.
- START in FIN: clears DONE, STATUS and CYCLES, re-asserts `CPU_RST`, enters LOAD or HOLD. START in LOAD, HOLD or RUN is ignored.
- `BUSY`=1 in LOAD, HOLD and RUN.
- Counter widths: CYCLES saturates at 2^CNT_W-1 when limit=0.

## Timing
- Reset values: `CPU_RST`=1, `WE`=0, `W_Ins`=0, `S_READY`=0, `BUSY`=0, `DONE`=0, `STATUS`=00, `CYCLES`=0, `FINAL_PC`=0; state IDLE.
- `RST_N` assertion mid-operation forces reset values immediately (asynchronous). Any partial program load is abandoned.
- START at edge t → BUSY=1 and S_READY=1 from t+1.
- Handshake at edge t → WE=1 during t+1..t+2 only.
- Last load handshake at t → HOLD from t+1 → CPU_RST falls at t+1+RST_HOLD.
- RUN exit detected at edge t → DONE=1 and BUSY=0 from t+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset: RST_N low mid-RUN → all outputs at reset values in the same cycle, without waiting for a clock edge.
- Load 4 words 0x20100001..0x20100004 with S_VALID gaps → WE is high exactly 4 cycles with matching W_Ins order. CPU_RST falls 2 cycles after the last handshake.
- Stop-PC exit: STOP_PC=0x10, limit=0, LEN=4 → STATUS=01, FINAL_PC=0x10, CYCLES=4.
- Timeout: STOP_PC unreachable (0xFFFFFFFC), CYCLE_LIMIT=160 → STATUS=10, CYCLES=160, DONE set on the cycle after the 160th run cycle.
- Simultaneous exits and abort: a PC match on the limit cycle → STATUS=01. ABORT during LOAD after 2 of 5 words → STATUS=11, S_READY=0.
- Restart: START in FIN with LEN=0 → HOLD, then RUN, with CYCLES cleared. START pulses during RUN are ignored.
